// File: rtl/parity_pkg.sv
// Shared types and constants for the serial frame parity checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serial_frame_parity_checker.sv
// Deserialises MSB-first frames of DATA_WIDTH bits plus a parity bit, checks
// parity against a per-frame even/odd mode and counts errored frames.
module serial_frame_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  odd_mode,
  input  logic                  data_in,
  input  logic                  data_valid,
  input  logic                  err_clr,
  output logic                  checking,
  output logic                  running_parity,
  output logic                  frame_done,
  output logic                  parity_error,
  output logic                  frame_abort,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  error_count
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic                  odd_q, odd_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rp_q, rp_d;
  logic                  checking_q, checking_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic                  abort_q, abort_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  err;
  logic                  err_inc;

  // NOTE: every signal gets a default at the top so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    odd_d   = odd_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rp_d    = rp_q;
    perr_d  = perr_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    err     = 1'b0;
    err_inc = 1'b0;

    // start sets up a fresh frame from any state; mid-frame it abandons the old one.
    if (start) begin
      state_d = DATA;
      odd_d   = odd_mode ? PAR_ODD : PAR_EVEN;
      cnt_d   = '0;
      shift_d = '0;
      rp_d    = 1'b0;
      abort_d = (state_q == DATA) || (state_q == PARITY);
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        DATA: begin
          if (data_valid) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], data_in};
            rp_d    = rp_q ^ data_in;
            if (cnt_q == LAST_BIT) begin
              state_d = PARITY;
            end else begin
              cnt_d = cnt_q + BW'(1);
            end
          end
        end
        PARITY: begin
          if (data_valid) begin
            err     = rp_q ^ data_in ^ (odd_q == PAR_ODD);
            perr_d  = err;
            dout_d  = shift_q;
            err_inc = err;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    checking_d = (state_d == DATA) || (state_d == PARITY);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      odd_q      <= PAR_EVEN;
      cnt_q      <= '0;
      shift_q    <= '0;
      rp_q       <= 1'b0;
      checking_q <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      abort_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      odd_q      <= odd_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rp_q       <= rp_d;
      checking_q <= checking_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      abort_q    <= abort_d;
      dout_q     <= dout_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (err_inc),
    .clr    (err_clr),
    .count  (error_count)
  );

  assign checking       = checking_q;
  assign running_parity = rp_q;
  assign frame_done     = done_q;
  assign parity_error   = perr_q;
  assign frame_abort    = abort_q;
  assign data_out       = dout_q;

endmodule
